// File: rtl/work_sender_pkg.sv
// Shared constants and TX state encoding for the work_sender host-side serial block.
package work_sender_pkg;

    localparam int unsigned WorkBytes  = 76;
    localparam int unsigned NonceBytes = 4;
    localparam int unsigned WorkBits   = WorkBytes * 8;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StHold,
        StDrain
    } tx_state_e;

endpackage

// File: rtl/work_sender_uart.sv
// 8N1 UART with independent tx/rx. Carries no reset: every counter runs down to idle on its own,
// so a frame in flight always completes.
module work_sender_uart #(
    parameter int unsigned Clock       = 25000000,
    parameter int unsigned Baud        = 57600,
    parameter int unsigned SamplePoint = 8
) (
    input  logic       clk_i,
    input  logic       rx_i,
    output logic       tx_o,
    input  logic       tx_start_i,
    input  logic [7:0] tx_byte_i,
    output logic       tx_busy_o,
    output logic [7:0] rx_byte_o,
    output logic       rx_data_ready_o,
    output logic       rx_error_o
);

    localparam int unsigned ClksPerBit = Clock / Baud;
    localparam int unsigned DivW       = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
    // SamplePoint is in sixteenths of a bit period.
    localparam int unsigned SampleOffs = ClksPerBit * SamplePoint / 16;
    localparam logic [DivW-1:0] BitReload   = DivW'(ClksPerBit - 1);
    localparam logic [DivW-1:0] StartReload = (SampleOffs > 1) ? DivW'(SampleOffs - 1) : '0;

    logic [3:0]      tx_bits_q, tx_bits_d;
    logic [DivW-1:0] tx_div_q, tx_div_d;
    logic [9:0]      tx_frame_q, tx_frame_d;

    always_comb begin
        tx_bits_d  = tx_bits_q;
        tx_div_d   = tx_div_q;
        tx_frame_d = tx_frame_q;
        if (tx_bits_q == 4'd0) begin
            if (tx_start_i) begin
                tx_frame_d = {1'b1, tx_byte_i, 1'b0};
                tx_bits_d  = 4'd10;
                tx_div_d   = BitReload;
            end
        end else if (tx_div_q == '0) begin
            tx_frame_d = {1'b1, tx_frame_q[9:1]};
            tx_bits_d  = tx_bits_q - 4'd1;
            tx_div_d   = BitReload;
        end else begin
            tx_div_d = tx_div_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        tx_bits_q  <= tx_bits_d;
        tx_div_q   <= tx_div_d;
        tx_frame_q <= tx_frame_d;
    end

    assign tx_busy_o = (tx_bits_q != 4'd0);
    assign tx_o      = tx_busy_o ? tx_frame_q[0] : 1'b1;

    logic [1:0]      rx_sync_q;
    logic            rx_prev_q;
    logic            rx_s;
    logic [3:0]      rx_bits_q, rx_bits_d;
    logic [DivW-1:0] rx_div_q, rx_div_d;
    logic [7:0]      rx_shreg_q, rx_shreg_d;
    logic [7:0]      rx_byte_q, rx_byte_d;
    logic            rx_ready_q, rx_ready_d;
    logic            rx_err_q, rx_err_d;

    assign rx_s = rx_sync_q[1];

    always_comb begin
        rx_bits_d  = rx_bits_q;
        rx_div_d   = rx_div_q;
        rx_shreg_d = rx_shreg_q;
        rx_byte_d  = rx_byte_q;
        rx_ready_d = 1'b0;
        rx_err_d   = 1'b0;
        if (rx_bits_q == 4'd0) begin
            if (rx_prev_q && !rx_s) begin
                rx_bits_d = 4'd10;
                rx_div_d  = StartReload;
            end
        end else if (rx_div_q == '0) begin
            rx_div_d  = BitReload;
            rx_bits_d = rx_bits_q - 4'd1;
            if (rx_bits_q == 4'd10) begin
                // Start bit gone high again: glitch, not a frame.
                if (rx_s) rx_bits_d = 4'd0;
            end else if (rx_bits_q == 4'd1) begin
                if (rx_s) begin
                    rx_ready_d = 1'b1;
                    rx_byte_d  = rx_shreg_q;
                end else begin
                    rx_err_d = 1'b1;
                end
            end else begin
                rx_shreg_d = {rx_s, rx_shreg_q[7:1]};
            end
        end else begin
            rx_div_d = rx_div_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        rx_sync_q  <= {rx_sync_q[0], rx_i};
        rx_prev_q  <= rx_s;
        rx_bits_q  <= rx_bits_d;
        rx_div_q   <= rx_div_d;
        rx_shreg_q <= rx_shreg_d;
        rx_byte_q  <= rx_byte_d;
        rx_ready_q <= rx_ready_d;
        rx_err_q   <= rx_err_d;
    end

    assign rx_byte_o       = rx_byte_q;
    assign rx_data_ready_o = rx_ready_q;
    assign rx_error_o      = rx_err_q;

endmodule

// File: rtl/work_sender.sv
// Serializes 608-bit work units MSB byte first and gathers returned 4-byte nonces.
// Define NONCE_RESYNC_EN to drop a partial nonce after ResyncCycles of rx silence.
module work_sender
    import work_sender_pkg::*;
#(
    parameter int unsigned Clock       = 25000000,
    parameter int unsigned Baud        = 57600,
    parameter int unsigned SamplePoint = 8
`ifdef NONCE_RESYNC_EN
    ,
    parameter int unsigned ResyncCycles = 43400
`endif
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                rx_i,
    output logic                tx_o,
    input  logic [WorkBits-1:0] work_i,
    input  logic                work_valid_i,
    output logic                work_ready_o,
    output logic                tx_busy_o,
    output logic [31:0]         nonce_o,
    output logic                nonce_valid_o,
    output logic [7:0]          drop_count_o
);

    logic       tx_start;
    logic [7:0] tx_byte;
    logic       uart_tx_busy;
    logic [7:0] uart_rx_byte;
    logic       uart_rx_ready;
    logic       uart_rx_error;

    work_sender_uart #(
        .Clock       (Clock),
        .Baud        (Baud),
        .SamplePoint (SamplePoint)
    ) u_uart (
        .clk_i           (clk_i),
        .rx_i            (rx_i),
        .tx_o            (tx_o),
        .tx_start_i      (tx_start),
        .tx_byte_i       (tx_byte),
        .tx_busy_o       (uart_tx_busy),
        .rx_byte_o       (uart_rx_byte),
        .rx_data_ready_o (uart_rx_ready),
        .rx_error_o      (uart_rx_error)
    );

    tx_state_e           state_q, state_d;
    logic [WorkBits-1:0] shreg_q, shreg_d;
    logic [6:0]          tx_cnt_q, tx_cnt_d;

    assign tx_byte   = shreg_q[WorkBits-1 -: 8];
    assign tx_busy_o = (state_q != StIdle);

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        tx_cnt_d     = tx_cnt_q;
        tx_start     = 1'b0;
        work_ready_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                work_ready_o = !uart_tx_busy;
                if (work_valid_i && work_ready_o) begin
                    shreg_d  = work_i;
                    tx_cnt_d = '0;
                    state_d  = StStart;
                end
            end
            StStart: begin
                tx_start = 1'b1;
                shreg_d  = {shreg_q[WorkBits-9:0], 8'h00};
                state_d  = StHold;
            end
            // The uart raises its busy flag one cycle after tx_start.
            StHold: state_d = StDrain;
            StDrain: begin
                if (!uart_tx_busy) begin
                    tx_cnt_d = tx_cnt_q + 7'd1;
                    state_d  = (tx_cnt_d == 7'(WorkBytes)) ? StIdle : StStart;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            tx_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            tx_cnt_q <= tx_cnt_d;
        end
        shreg_q <= shreg_d;
    end

    logic [1:0]  rx_cnt_q, rx_cnt_d;
    logic [23:0] nshreg_q, nshreg_d;
    logic [31:0] nonce_q, nonce_d;
    logic        nonce_valid_q, nonce_valid_d;
    logic [7:0]  drop_q, drop_d;
    logic        drop_inc;

`ifdef NONCE_RESYNC_EN
    localparam int unsigned GapW = $clog2(ResyncCycles + 1);
    logic [GapW-1:0] gap_q, gap_d;
`endif

    always_comb begin
        rx_cnt_d      = rx_cnt_q;
        nshreg_d      = nshreg_q;
        nonce_d       = nonce_q;
        nonce_valid_d = 1'b0;
        drop_d        = drop_q;
        drop_inc      = 1'b0;
`ifdef NONCE_RESYNC_EN
        gap_d         = '0;
`endif
        if (uart_rx_error) begin
            rx_cnt_d = '0;
            drop_inc = (rx_cnt_q != 2'd0);
        end else if (uart_rx_ready) begin
            nshreg_d = {nshreg_q[15:0], uart_rx_byte};
            rx_cnt_d = rx_cnt_q + 2'd1;
            if (rx_cnt_q == 2'(NonceBytes - 1)) begin
                nonce_d       = {nshreg_q, uart_rx_byte};
                nonce_valid_d = 1'b1;
            end
        end
`ifdef NONCE_RESYNC_EN
        else if (rx_cnt_q != 2'd0) begin
            if (gap_q == GapW'(ResyncCycles)) begin
                rx_cnt_d = '0;
                drop_inc = 1'b1;
            end else begin
                gap_d = gap_q + 1'b1;
            end
        end
`endif
        if (drop_inc && drop_q != 8'hff) drop_d = drop_q + 8'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_cnt_q      <= '0;
            nshreg_q      <= '0;
            nonce_q       <= '0;
            nonce_valid_q <= 1'b0;
            drop_q        <= '0;
`ifdef NONCE_RESYNC_EN
            gap_q         <= '0;
`endif
        end else begin
            rx_cnt_q      <= rx_cnt_d;
            nshreg_q      <= nshreg_d;
            nonce_q       <= nonce_d;
            nonce_valid_q <= nonce_valid_d;
            drop_q        <= drop_d;
`ifdef NONCE_RESYNC_EN
            gap_q         <= gap_d;
`endif
        end
    end

    assign nonce_o       = nonce_q;
    assign nonce_valid_o = nonce_valid_q;
    assign drop_count_o  = drop_q;

endmodule
